// File: rtl/quad_step_decoder.sv
// quad_step_decoder: sync + glitch-filter quadrature A/B, emit step/dir pulses and sticky illegal-transition error
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int FILT_WIDTH  = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_a,
  input  logic i_b,
  input  logic i_enable,
  input  logic i_err_clr,
  output logic o_step,
  output logic o_dir,
  output logic o_err
);
  localparam logic [FILT_WIDTH-1:0] LAST = FILT_WIDTH'(FILT_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [FILT_WIDTH-1:0] ca_q, ca_d, cb_q, cb_d;
  logic fa_q, fa_d, fb_q, fb_d;
  logic [1:0] p_q, p_d, cur, pos_c, pos_p, delta;
  logic mis_a, mis_b, done_a, done_b, legal, illegal;
  logic step_q, step_d, dir_q, dir_d, err_q, err_d;
  always_comb begin
    sa_d = {sa_q[SYNC_STAGES-2:0], i_a};
    sb_d = {sb_q[SYNC_STAGES-2:0], i_b};
    mis_a = sa_q[SYNC_STAGES-1] ^ fa_q;
    mis_b = sb_q[SYNC_STAGES-1] ^ fb_q;
    done_a = mis_a && ca_q == LAST;
    done_b = mis_b && cb_q == LAST;
    ca_d = (mis_a && !done_a) ? ca_q + 1'b1 : '0;
    cb_d = (mis_b && !done_b) ? cb_q + 1'b1 : '0;
    fa_d = done_a ? ~fa_q : fa_q;
    fb_d = done_b ? ~fb_q : fb_q;
    cur = {fa_q, fb_q};
    // Gray code -> position along the forward cycle 00,01,11,10
    pos_c = {cur[1], ^cur};
    pos_p = {p_q[1], ^p_q};
    delta = pos_c - pos_p;
    legal = delta[0];
    illegal = delta == 2'd2;
    p_d = cur;
    step_d = i_enable && legal;
    dir_d = step_d ? (delta == 2'd1) : dir_q;
    err_d = (i_enable && illegal) || (err_q && !i_err_clr);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sa_q <= '0;
      sb_q <= '0;
      ca_q <= '0;
      cb_q <= '0;
      fa_q <= 1'b0;
      fb_q <= 1'b0;
      p_q <= 2'b00;
      step_q <= 1'b0;
      dir_q <= 1'b1;
      err_q <= 1'b0;
    end else begin
      sa_q <= sa_d;
      sb_q <= sb_d;
      ca_q <= ca_d;
      cb_q <= cb_d;
      fa_q <= fa_d;
      fb_q <= fb_d;
      p_q <= p_d;
      step_q <= step_d;
      dir_q <= dir_d;
      err_q <= err_d;
    end
  end
  assign o_step = step_q;
  assign o_dir = dir_q;
  assign o_err = err_q;
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: vector table, hand sequences and random stimulus against a reference model
module tb_quad_step_decoder;
  localparam int SYNC = 2;
  localparam int F = 4;
  localparam logic [1:0] FWD [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
  logic i_clk = 1'b0, i_rst = 1'b1, i_a = 1'b0, i_b = 1'b0, i_enable = 1'b1, i_err_clr = 1'b0;
  logic o_step, o_dir, o_err;
  int passed = 0, total = 0, cnt = 0;
  bit chk_on = 0;
  typedef struct {
    logic [1:0] ab;
    logic en, clr, z;
    int hold, up, dn, err, cnt;
  } vec_t;
  vec_t tbl [20];
  int k, la, lb;
  logic ain [16], bin [16], sah_a [16], sah_b [16];
  logic mfa, mfb, mstep, mdir, merr;
  logic [1:0] mp, mc;

  quad_step_decoder #(.SYNC_STAGES(SYNC), .FILT_CYCLES(F), .FILT_WIDTH(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_a(i_a), .i_b(i_b), .i_enable(i_enable),
    .i_err_clr(i_err_clr), .o_step(o_step), .o_dir(o_dir), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: a filtered level flips once the last F synchronised samples since its
  // previous flip all disagree with it; decode uses the forward-successor table.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      k <= 0; la <= 0; lb <= 0; mfa <= 1'b0; mfb <= 1'b0;
      mp <= 2'b00; mc <= 2'b00; mstep <= 1'b0; mdir <= 1'b1; merr <= 1'b0;
    end else begin : mdl
      int e;
      logic sa, sb, oka, okb, up, dn, il;
      e = k + 1;
      sa = (e > SYNC) ? ain[(e - SYNC) & 15] : 1'b0;
      sb = (e > SYNC) ? bin[(e - SYNC) & 15] : 1'b0;
      oka = sa != mfa;
      okb = sb != mfb;
      for (int j = 1; j < F; j++) begin
        if (e - j <= la || sah_a[(e - j) & 15] == mfa) oka = 1'b0;
        if (e - j <= lb || sah_b[(e - j) & 15] == mfb) okb = 1'b0;
      end
      up = mc != mp && FWD[mp] == mc;
      dn = mc != mp && FWD[mc] == mp;
      il = mc != mp && !up && !dn;
      mstep <= i_enable && (up || dn);
      mdir <= (i_enable && (up || dn)) ? up : mdir;
      merr <= (i_enable && il) || (merr && !i_err_clr);
      mp <= mc;
      mc <= {oka ? sa : mfa, okb ? sb : mfb};
      mfa <= oka ? sa : mfa;
      mfb <= okb ? sb : mfb;
      la <= oka ? e : la;
      lb <= okb ? e : lb;
      ain[e & 15] <= i_a;
      bin[e & 15] <= i_b;
      sah_a[e & 15] <= sa;
      sah_b[e & 15] <= sb;
      k <= e;
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst && chk_on) begin
      chk("model_step", o_step, mstep);
      chk("model_dir", o_dir, mdir);
      chk("model_err", o_err, merr);
    end
  end

  task automatic run_rows(input int lo, input int hi);
    int up, dn;
    for (int i = lo; i <= hi; i++) begin
      if (tbl[i].z) cnt = 0;
      {i_a, i_b} = tbl[i].ab;
      i_enable = tbl[i].en;
      i_err_clr = tbl[i].clr;
      up = 0;
      dn = 0;
      repeat (tbl[i].hold) begin
        @(negedge i_clk);
        if (o_step) begin
          if (o_dir) begin up++; cnt = (cnt + 1) % 3; end
          else begin dn++; cnt = (cnt + 2) % 3; end
        end
      end
      i_err_clr = 1'b0;
      chk($sformatf("row%0d_up", i), up, tbl[i].up);
      chk($sformatf("row%0d_dn", i), dn, tbl[i].dn);
      chk($sformatf("row%0d_err", i), o_err, tbl[i].err);
      chk($sformatf("row%0d_cnt", i), cnt, tbl[i].cnt);
    end
  endtask

  initial begin
    tbl[0]  = '{2'b01, 1'b1, 1'b0, 1'b1, 10, 1, 0, 0, 1};
    tbl[1]  = '{2'b11, 1'b1, 1'b0, 1'b0, 10, 1, 0, 0, 2};
    tbl[2]  = '{2'b10, 1'b1, 1'b0, 1'b0, 10, 1, 0, 0, 0};
    tbl[3]  = '{2'b00, 1'b1, 1'b0, 1'b0, 10, 1, 0, 0, 1};
    tbl[4]  = '{2'b10, 1'b1, 1'b0, 1'b1, 10, 0, 1, 0, 2};
    tbl[5]  = '{2'b11, 1'b1, 1'b0, 1'b0, 10, 0, 1, 0, 1};
    tbl[6]  = '{2'b01, 1'b1, 1'b0, 1'b0, 10, 0, 1, 0, 0};
    tbl[7]  = '{2'b00, 1'b1, 1'b0, 1'b0, 10, 0, 1, 0, 2};
    tbl[8]  = '{2'b10, 1'b1, 1'b0, 1'b0, 3, 0, 0, 0, 2};
    tbl[9]  = '{2'b00, 1'b1, 1'b0, 1'b0, 10, 0, 0, 0, 2};
    tbl[10] = '{2'b10, 1'b1, 1'b0, 1'b0, 4, 0, 0, 0, 2};
    tbl[11] = '{2'b00, 1'b1, 1'b0, 1'b0, 12, 1, 1, 0, 2};
    tbl[12] = '{2'b11, 1'b1, 1'b0, 1'b0, 10, 0, 0, 1, 2};
    tbl[13] = '{2'b11, 1'b1, 1'b0, 1'b0, 5, 0, 0, 1, 2};
    tbl[14] = '{2'b11, 1'b1, 1'b1, 1'b0, 2, 0, 0, 0, 2};
    tbl[15] = '{2'b11, 1'b1, 1'b0, 1'b0, 3, 0, 0, 0, 2};
    tbl[16] = '{2'b01, 1'b0, 1'b0, 1'b0, 10, 0, 0, 0, 2};
    tbl[17] = '{2'b11, 1'b1, 1'b0, 1'b0, 10, 1, 0, 0, 0};
    tbl[18] = '{2'b01, 1'b1, 1'b0, 1'b0, 10, 0, 1, 0, 2};
    tbl[19] = '{2'b00, 1'b1, 1'b0, 1'b0, 10, 0, 1, 0, 1};
    repeat (2) @(negedge i_clk);
    chk("rst_step", o_step, 0);
    chk("rst_dir", o_dir, 1);
    chk("rst_err", o_err, 0);
    i_rst = 1'b0;
    chk_on = 1;
    run_rows(0, 15);
    // illegal 11->00 whose error lands on the same edge as a clear request
    {i_a, i_b} = 2'b00;
    repeat (6) @(negedge i_clk);
    chk("coinc_pre_err", o_err, 0);
    i_err_clr = 1'b1;
    @(negedge i_clk);
    i_err_clr = 1'b0;
    chk("coinc_err", o_err, 1);
    chk("coinc_step", o_step, 0);
    repeat (3) @(negedge i_clk);
    chk("coinc_sticky", o_err, 1);
    i_err_clr = 1'b1;
    @(negedge i_clk);
    i_err_clr = 1'b0;
    chk("coinc_clear", o_err, 0);
    run_rows(16, 19);
    // reset mid-filter with A held high
    i_a = 1'b1;
    repeat (4) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("async_rst_step", o_step, 0);
    chk("async_rst_dir", o_dir, 1);
    chk("async_rst_err", o_err, 0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge i_clk);
      chk($sformatf("post_rst_step_e%0d", n), o_step, n == 7);
      if (n == 7) chk("post_rst_dir", o_dir, 0);
    end
    for (int s = 0; s < 300; s++) begin
      {i_a, i_b} = 2'($urandom_range(0, 3));
      i_enable = $urandom_range(0, 9) != 0;
      i_err_clr = $urandom_range(0, 7) == 0;
      repeat ($urandom_range(1, 12)) @(negedge i_clk);
    end
    i_err_clr = 1'b0;
    repeat (12) @(negedge i_clk);
    chk_on = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
